// File: rtl/cache_ctrl.sv
// Direct-mapped, read-allocate, write-through/no-write-allocate cache controller.
// Drives external valid/tag/data arrays (1-cycle read latency) and a simple line-read / word-write bus.
module cache_ctrl #(
   parameter int INDEX_W    = 6,
   parameter int TAG_W      = 22,
   parameter int LINE_WORDS = 4,
   localparam int OFF_W     = $clog2(LINE_WORDS)
) (
   input  logic                     CK,
   input  logic                     rst,
   input  logic                     core_req,
   input  logic                     core_we,
   input  logic [31:0]              core_addr,
   input  logic [31:0]              core_wdata,
   input  logic [3:0]               core_wstrb,
   output logic [31:0]              core_rdata,
   output logic                     core_ready,
   output logic                     va_cs,
   output logic                     va_oe,
   output logic [INDEX_W-1:0]       va_idx,
   input  logic                     va_vbit,
   output logic                     ta_cs,
   output logic                     ta_we,
   output logic [INDEX_W-1:0]       ta_idx,
   output logic [TAG_W-1:0]         ta_wtag,
   input  logic [TAG_W-1:0]         ta_rtag,
   output logic                     da_cs,
   output logic [3:0]               da_we,
   output logic [INDEX_W+OFF_W-1:0] da_addr,
   output logic [31:0]              da_wdata,
   input  logic [31:0]              da_rdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_wstrb,
   input  logic                     mem_ack,
   input  logic                     mem_rvalid,
   input  logic [31:0]              mem_rdata,
   output logic [31:0]              hit_cnt,
   output logic [31:0]              miss_cnt
);

   localparam int IDX_LO = OFF_W + 2;
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, CHECK, REFILL_REQ, REFILL, SET_VALID, WR_MEM} state_t;

   state_t              state, nxt;
   logic [31:0]         a_addr;
   logic                a_we;
   logic [31:0]         a_wdata;
   logic [3:0]          a_wstrb;
   logic [OFF_W-1:0]    beat;
   logic [31:0]         crit;
   logic                hit;

   logic [INDEX_W-1:0]  a_idx, r_idx;
   logic [TAG_W-1:0]    a_tag;
   logic [OFF_W-1:0]    a_off, r_off;

   assign a_idx = a_addr[IDX_LO +: INDEX_W];
   assign a_tag = a_addr[31 -: TAG_W];
   assign a_off = a_addr[2 +: OFF_W];
   assign r_idx = core_addr[IDX_LO +: INDEX_W];
   assign r_off = core_addr[2 +: OFF_W];
   assign hit   = va_vbit && (ta_rtag == a_tag);

   always_ff @(posedge CK or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         a_addr   <= '0;
         a_we     <= 1'b0;
         a_wdata  <= '0;
         a_wstrb  <= '0;
         beat     <= '0;
         crit     <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && core_req) begin
            a_addr  <= core_addr;
            a_we    <= core_we;
            a_wdata <= core_wdata;
            a_wstrb <= core_wstrb;
         end
         if (state == CHECK && hit)
            hit_cnt <= hit_cnt + 32'd1;
         if (state == CHECK && !hit && !a_we)
            miss_cnt <= miss_cnt + 32'd1;
         // Beats only count once REFILL is entered, so a beat alongside the request ack is dropped.
         if (state == REFILL && mem_rvalid) begin
            beat <= (beat == LAST) ? '0 : beat + 1'b1;
            if (beat == a_off)
               crit <= mem_rdata;
         end
      end
   end

   always_comb begin
      nxt        = state;
      core_rdata = '0;
      core_ready = 1'b0;
      va_cs      = 1'b0;
      va_oe      = 1'b0;
      va_idx     = '0;
      ta_cs      = 1'b0;
      ta_we      = 1'b0;
      ta_idx     = '0;
      ta_wtag    = '0;
      da_cs      = 1'b0;
      da_we      = '0;
      da_addr    = '0;
      da_wdata   = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      case (state)
         IDLE: if (core_req) begin
            va_cs   = 1'b1;
            va_oe   = 1'b1;
            va_idx  = r_idx;
            ta_cs   = 1'b1;
            ta_idx  = r_idx;
            da_cs   = 1'b1;
            da_addr = {r_idx, r_off};
            nxt     = CHECK;
         end
         CHECK: begin
            if (a_we) begin
               if (hit) begin
                  da_cs    = 1'b1;
                  da_we    = a_wstrb;
                  da_addr  = {a_idx, a_off};
                  da_wdata = a_wdata;
               end
               nxt = WR_MEM;
            end else if (hit) begin
               core_rdata = da_rdata;
               core_ready = 1'b1;
               nxt        = IDLE;
            end else begin
               nxt = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {a_addr[31:IDX_LO], {IDX_LO{1'b0}}};
            if (mem_ack)
               nxt = REFILL;
         end
         REFILL: if (mem_rvalid) begin
            da_cs    = 1'b1;
            da_we    = 4'hF;
            da_addr  = {a_idx, beat};
            da_wdata = mem_rdata;
            // Tag goes in with the last beat; the valid bit follows a cycle later.
            if (beat == LAST) begin
               ta_cs   = 1'b1;
               ta_we   = 1'b1;
               ta_idx  = a_idx;
               ta_wtag = a_tag;
               nxt     = SET_VALID;
            end
         end
         SET_VALID: begin
            va_cs      = 1'b1;
            va_idx     = a_idx;
            core_rdata = crit;
            core_ready = 1'b1;
            nxt        = IDLE;
         end
         WR_MEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {a_addr[31:2], 2'b00};
            mem_wdata = a_wdata;
            mem_wstrb = a_wstrb;
            if (mem_ack) begin
               core_ready = 1'b1;
               nxt        = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural array/bus models plus a line-level cache reference model.
module tb_cache_ctrl;

   logic        CK = 1'b0;
   logic        rst = 1'b0;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic [3:0]  core_wstrb = '0;
   logic [31:0] core_rdata;
   logic        core_ready;
   logic        va_cs, va_oe, va_vbit;
   logic [5:0]  va_idx, ta_idx;
   logic        ta_cs, ta_we;
   logic [21:0] ta_wtag, ta_rtag;
   logic        da_cs;
   logic [3:0]  da_we;
   logic [7:0]  da_addr;
   logic [31:0] da_wdata, da_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] hit_cnt, miss_cnt;

   int total = 0, bad = 0;

   cache_ctrl dut (
      .CK(CK), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_wstrb(core_wstrb),
      .core_rdata(core_rdata), .core_ready(core_ready),
      .va_cs(va_cs), .va_oe(va_oe), .va_idx(va_idx), .va_vbit(va_vbit),
      .ta_cs(ta_cs), .ta_we(ta_we), .ta_idx(ta_idx), .ta_wtag(ta_wtag), .ta_rtag(ta_rtag),
      .da_cs(da_cs), .da_we(da_we), .da_addr(da_addr), .da_wdata(da_wdata), .da_rdata(da_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 CK = ~CK;

   // External arrays: registered reads, contents survive controller reset.
   logic        vmem [64];
   logic [21:0] tmem [64];
   logic [31:0] dmem [256];
   int          va_wr = 0, ta_wr = 0, da_wr = 0;
   logic [5:0]  last_va_widx = '0;
   logic [3:0]  last_da_we = '0;

   initial begin
      va_vbit = 1'b0; ta_rtag = '0; da_rdata = '0;
      for (int i = 0; i < 64; i++) begin vmem[i] = 1'b0; tmem[i] = '0; end
      for (int i = 0; i < 256; i++) dmem[i] = '0;
   end

   always @(posedge CK) begin
      if (va_cs) begin
         if (va_oe) va_vbit <= vmem[va_idx];
         else begin vmem[va_idx] <= 1'b1; va_wr <= va_wr + 1; last_va_widx <= va_idx; end
      end
      if (ta_cs) begin
         if (ta_we) begin tmem[ta_idx] <= ta_wtag; ta_wr <= ta_wr + 1; end
         else ta_rtag <= tmem[ta_idx];
      end
      if (da_cs) begin
         if (da_we != 4'h0) begin
            for (int b = 0; b < 4; b++) if (da_we[b]) dmem[da_addr][8*b +: 8] <= da_wdata[8*b +: 8];
            da_wr <= da_wr + 1; last_da_we <= da_we;
         end else da_rdata <= dmem[da_addr];
      end
   end

   // Backing memory seen by the bus, and the reference model's own copy.
   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic        ref_v [64];
   logic [21:0] ref_t [64];
   logic [31:0] ref_hit = '0, ref_miss = '0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Reference: per-line valid/tag, write-through memory, counter rules.
   task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] st, output logic hit, output logic [31:0] rd);
      logic [5:0]  idx;
      logic [31:0] wa;
      idx = addr[9:4];
      wa  = {addr[31:2], 2'b00};
      hit = ref_v[idx] && (ref_t[idx] == addr[31:10]);
      rd  = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
      if (hit) ref_hit = ref_hit + 32'd1;
      if (we) ref_mem[wa] = merge(rd, wd, st);
      else if (!hit) begin
         ref_miss = ref_miss + 32'd1;
         ref_v[idx] = 1'b1;
         ref_t[idx] = addr[31:10];
      end
   endtask

   // Drives one core access and plays the bus. abort_beat >= 0 asserts reset once that many beats landed.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                         input int abort_beat, output logic [31:0] rd, output int lat, output int mreq_cyc,
                         output int refill_cyc, output int nmw, output int nmr, output logic [31:0] maddr,
                         output logic done);
      int cyc, wait_left, beats;
      logic rd_phase, was_rd;
      logic [31:0] line;
      @(negedge CK);
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd; core_wstrb = st;
      cyc = 1; done = 1'b0; rd = '0; lat = 0; mreq_cyc = 0; refill_cyc = 0; nmw = 0; nmr = 0;
      maddr = '0; beats = 0; rd_phase = 1'b0; line = '0;
      wait_left = $urandom_range(0, 3);
      while (!done && cyc < 300) begin
         @(negedge CK);
         cyc++;
         core_req = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (abort_beat >= 0 && rd_phase && beats == abort_beat) begin
            rst = 1'b0;
            #1;
            done = 1'b1;
            break;
         end
         was_rd = rd_phase;
         if (was_rd) begin
            refill_cyc++;
            if ($urandom_range(0, 2) != 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = bus_rd(line + 32'(beats * 4));
               beats++;
               if (beats == 4) rd_phase = 1'b0;
            end
         end
         if (mem_req) begin
            if (!mem_we) mreq_cyc++;
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               maddr   = mem_addr;
               if (mem_we) begin
                  bus_mem[{mem_addr[31:2], 2'b00}] = merge(bus_rd({mem_addr[31:2], 2'b00}), mem_wdata, mem_wstrb);
                  nmw++;
               end else begin
                  nmr++;
                  rd_phase = 1'b1;
                  line = mem_addr;
                  // Stray beat alongside the ack must not be taken as beat 0.
                  if ($urandom_range(0, 1) == 1) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
               end
               wait_left = $urandom_range(0, 3);
            end else wait_left--;
         end
         #1;
         if (core_ready) begin rd = core_rdata; lat = cyc; done = 1'b1; end
      end
      @(negedge CK);
      mem_ack = 1'b0; mem_rvalid = 1'b0;
   endtask

   logic [31:0] rd, maddr, exp_rd;
   logic        done, exp_hit;
   int          lat, mreq_cyc, refill_cyc, nmw, nmr;
   int          va0, ta0, da0;

   task automatic test_reset();
      total++;
      if ({core_ready, core_rdata, va_cs, va_oe, va_idx, ta_cs, ta_we, ta_idx, ta_wtag, da_cs, da_we,
           da_addr, da_wdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, hit_cnt, miss_cnt} !== '0) begin
         bad++; $display("FAIL reset_outputs: hit=%h miss=%h mem_req=%b core_ready=%b expected all 0",
                         hit_cnt, miss_cnt, mem_req, core_ready);
      end
      @(negedge CK); rst = 1'b1;
   endtask

   task automatic test_cold_load();
      ref_access(1'b0, 32'h0000_0104, '0, '0, exp_hit, exp_rd);
      va0 = va_wr;
      access(1'b0, 32'h0000_0104, '0, '0, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (!done) begin bad++; $display("FAIL cold_timeout: done=%b expected 1", done); end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL cold_rdata: got %h expected %h", rd, exp_rd); end
      total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_cnt); end
      total++; if (maddr !== 32'h0000_0100 || nmr !== 1) begin
         bad++; $display("FAIL cold_line_addr: got %h/%0d reads expected 00000100/1", maddr, nmr); end
      total++; if (va_wr !== va0 + 1 || last_va_widx !== 6'h10) begin
         bad++; $display("FAIL cold_va_write: got %0d writes idx %h expected 1 at 10", va_wr - va0, last_va_widx); end
      total++; if (lat !== 3 + mreq_cyc + refill_cyc) begin
         bad++; $display("FAIL cold_latency: got %0d expected %0d", lat, 3 + mreq_cyc + refill_cyc); end
   endtask

   task automatic test_hit();
      ref_access(1'b0, 32'h0000_0108, '0, '0, exp_hit, exp_rd);
      access(1'b0, 32'h0000_0108, '0, '0, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (lat !== 2) begin bad++; $display("FAIL hit_latency: got %0d expected 2", lat); end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL hit_rdata: got %h expected %h", rd, exp_rd); end
      total++; if (hit_cnt !== 32'd1 || nmr !== 0) begin
         bad++; $display("FAIL hit_cnt: got %0d (%0d mem reads) expected 1 (0)", hit_cnt, nmr); end
   endtask

   task automatic test_store_hit();
      logic [31:0] a1;
      a1 = init_word(32'h0000_0104);
      ref_access(1'b1, 32'h0000_0104, 32'h1234_5678, 4'b0011, exp_hit, exp_rd);
      da0 = da_wr;
      access(1'b1, 32'h0000_0104, 32'h1234_5678, 4'b0011, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (da_wr !== da0 + 1 || last_da_we !== 4'b0011) begin
         bad++; $display("FAIL store_hit_da: got %0d writes we=%b expected 1 we=0011", da_wr - da0, last_da_we); end
      total++; if (nmw !== 1 || maddr !== 32'h0000_0104) begin
         bad++; $display("FAIL store_hit_mem: got %0d writes addr %h expected 1 at 00000104", nmw, maddr); end
      ref_access(1'b0, 32'h0000_0104, '0, '0, exp_hit, exp_rd);
      access(1'b0, 32'h0000_0104, '0, '0, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (rd !== {a1[31:16], 16'h5678} || lat !== 2) begin
         bad++; $display("FAIL store_hit_reload: got %h lat %0d expected %h lat 2", rd, lat, {a1[31:16], 16'h5678}); end
      total++; if (hit_cnt !== ref_hit) begin bad++; $display("FAIL store_hit_cnt: got %0d expected %0d", hit_cnt, ref_hit); end
   endtask

   task automatic test_conflict();
      ref_access(1'b0, 32'h0000_0504, '0, '0, exp_hit, exp_rd);
      access(1'b0, 32'h0000_0504, '0, '0, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (rd !== exp_rd || nmr !== 1) begin
         bad++; $display("FAIL conflict_rdata: got %h (%0d reads) expected %h (1)", rd, nmr, exp_rd); end
      total++; if (tmem[6'h10] !== 22'd1) begin bad++; $display("FAIL conflict_tag: got %h expected 1", tmem[6'h10]); end
      total++; if (miss_cnt !== 32'd2) begin bad++; $display("FAIL conflict_miss_cnt: got %0d expected 2", miss_cnt); end
   endtask

   task automatic test_store_miss();
      logic [31:0] h0, m0;
      h0 = hit_cnt; m0 = miss_cnt; va0 = va_wr; ta0 = ta_wr; da0 = da_wr;
      ref_access(1'b1, 32'h0000_2228, 32'hCAFE_F00D, 4'b1111, exp_hit, exp_rd);
      access(1'b1, 32'h0000_2228, 32'hCAFE_F00D, 4'b1111, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (va_wr !== va0 || ta_wr !== ta0 || da_wr !== da0) begin
         bad++; $display("FAIL store_miss_arrays: got va/ta/da writes %0d/%0d/%0d expected 0/0/0",
                         va_wr - va0, ta_wr - ta0, da_wr - da0); end
      total++; if (nmw !== 1 || nmr !== 0 || bus_rd(32'h0000_2228) !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL store_miss_mem: got %0d writes %0d reads data %h expected 1/0/cafef00d",
                         nmw, nmr, bus_rd(32'h0000_2228)); end
      total++; if (hit_cnt !== h0 || miss_cnt !== m0) begin
         bad++; $display("FAIL store_miss_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, h0, m0); end
   endtask

   task automatic test_reset_refill();
      va0 = va_wr;
      access(1'b0, 32'h0000_0A48, '0, '0, 2, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++;
      if ({core_ready, core_rdata, va_cs, ta_cs, da_cs, da_we, mem_req, mem_addr, hit_cnt, miss_cnt} !== '0) begin
         bad++; $display("FAIL abort_outputs: mem_req=%b core_ready=%b da_cs=%b miss=%h expected all 0",
                         mem_req, core_ready, da_cs, miss_cnt);
      end
      @(negedge CK); rst = 1'b1;
      total++; if (va_wr !== va0 || vmem[6'h24] !== 1'b0) begin
         bad++; $display("FAIL abort_va: got %0d writes bit %b expected 0/0", va_wr - va0, vmem[6'h24]); end
      ref_hit = '0; ref_miss = '0;
      ref_access(1'b0, 32'h0000_0A48, '0, '0, exp_hit, exp_rd);
      access(1'b0, 32'h0000_0A48, '0, '0, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
      total++; if (miss_cnt !== 32'd1 || nmr !== 1 || rd !== exp_rd) begin
         bad++; $display("FAIL abort_reload: got miss %0d reads %0d data %h expected 1/1/%h", miss_cnt, nmr, rd, exp_rd); end
   endtask

   task automatic test_back_to_back();
      logic        we;
      logic [31:0] addr, wd;
      logic [3:0]  st;
      logic [5:0]  ix;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: ix = 6'h10; 1: ix = 6'h11; 2: ix = 6'h22; default: ix = 6'h30;
         endcase
         addr = {20'h0, 2'($urandom_range(0, 3)), ix, 2'($urandom_range(0, 3)), 2'b00};
         we   = ($urandom_range(0, 2) == 0);
         wd   = $urandom;
         st   = 4'($urandom_range(1, 15));
         ref_access(we, addr, wd, st, exp_hit, exp_rd);
         access(we, addr, wd, st, -1, rd, lat, mreq_cyc, refill_cyc, nmw, nmr, maddr, done);
         total++;
         if (!done) begin bad++; $display("FAIL rand_timeout[%0d]: done=%b expected 1", n, done); end
         else if (!we && rd !== exp_rd) begin
            bad++; $display("FAIL rand_rdata[%0d]: addr %h got %h expected %h", n, addr, rd, exp_rd); end
         else if (!we && exp_hit && (lat !== 2 || nmr !== 0)) begin
            bad++; $display("FAIL rand_hit_timing[%0d]: got lat %0d reads %0d expected 2/0", n, lat, nmr); end
         else if (!we && !exp_hit && (nmr !== 1 || maddr !== {addr[31:4], 4'h0} || lat !== 3 + mreq_cyc + refill_cyc)) begin
            bad++; $display("FAIL rand_miss[%0d]: got reads %0d addr %h lat %0d expected 1/%h/%0d",
                            n, nmr, maddr, lat, {addr[31:4], 4'h0}, 3 + mreq_cyc + refill_cyc); end
         else if (we && (nmw !== 1 || maddr !== addr)) begin
            bad++; $display("FAIL rand_store[%0d]: got writes %0d addr %h expected 1/%h", n, nmw, maddr, addr); end
         total++;
         if (hit_cnt !== ref_hit || miss_cnt !== ref_miss) begin
            bad++; $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d", n, hit_cnt, miss_cnt, ref_hit, ref_miss); end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin ref_v[i] = 1'b0; ref_t[i] = '0; end
      #12;
      test_reset();
      test_cold_load();
      test_hit();
      test_store_hit();
      test_conflict();
      test_store_miss();
      test_reset_refill();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
